// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: boot ROM window, NOP encoding and FSM states.
package fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam logic [31:0] ROM_LAST_DEFAULT     = 32'hBFC00FFF;
    localparam logic [31:0] NOP_INSTR            = 32'h00000013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a NOP bubble, stall holds, otherwise loads the fetch.
// One-cycle latency; flush has priority over stall.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH     = 32,
    parameter int unsigned INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [ADDRESS_WIDTH-1:0]     pc_f,
    input  logic [ADDRESS_WIDTH-1:0]     pc_plus4_f,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_f,
    output logic [ADDRESS_WIDTH-1:0]     pc_d,
    output logic [ADDRESS_WIDTH-1:0]     pc_plus4_d,
    output logic [INSTRUCTION_WIDTH-1:0] instr_d,
    output logic                         valid_d
);

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(NOP_INSTR);

    logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d_nxt;
    logic [ADDRESS_WIDTH-1:0]     pc_plus4_q, pc_plus4_d_nxt;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d_nxt;
    logic                         valid_q, valid_d_nxt;

    always_comb begin
        pc_d_nxt       = pc_q;
        pc_plus4_d_nxt = pc_plus4_q;
        instr_d_nxt    = instr_q;
        valid_d_nxt    = valid_q;
        if (flush) begin
            pc_d_nxt       = '0;
            pc_plus4_d_nxt = '0;
            instr_d_nxt    = NOP;
            valid_d_nxt    = 1'b0;
        end else if (!stall) begin
            pc_d_nxt       = pc_f;
            pc_plus4_d_nxt = pc_plus4_f;
            instr_d_nxt    = instr_f;
            valid_d_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            pc_plus4_q <= '0;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d_nxt;
            pc_plus4_q <= pc_plus4_d_nxt;
            instr_q    <= instr_d_nxt;
            valid_q    <= valid_d_nxt;
        end
    end

    assign pc_d       = pc_q;
    assign pc_plus4_d = pc_plus4_q;
    assign instr_d    = instr_q;
    assign valid_d    = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC sequencing with redirect/stall, boot ROM bounds checking into a sticky
// FAULT state, and a count of valid instructions handed to decode. A = PCF combinationally.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH     = 32,
    parameter int unsigned              INSTRUCTION_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR      = ADDRESS_WIDTH'(fetch_pkg::RESET_VECTOR_DEFAULT),
    parameter logic [ADDRESS_WIDTH-1:0] ROM_LAST          = ADDRESS_WIDTH'(fetch_pkg::ROM_LAST_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         StallF,
    input  logic                         StallD,
    input  logic                         FlushD,
    input  logic                         PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0]     PCTargetE,
    output logic [ADDRESS_WIDTH-1:0]     A,
    input  logic [INSTRUCTION_WIDTH-1:0] RD,
    output logic [ADDRESS_WIDTH-1:0]     PCD,
    output logic [ADDRESS_WIDTH-1:0]     PCPlus4D,
    output logic [INSTRUCTION_WIDTH-1:0] InstrD,
    output logic                         ValidD,
    output logic                         FetchFault,
    output logic [31:0]                  InstrCount
);

    // Bounds are compared one bit wider so a PC+4 that wraps still reads as out of range.
    localparam logic [ADDRESS_WIDTH:0] ROM_LO_EXT = {1'b0, RESET_VECTOR};
    localparam logic [ADDRESS_WIDTH:0] ROM_HI_EXT = {1'b0, ROM_LAST} - (ADDRESS_WIDTH+1)'(3);

    fetch_state_e               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
    logic                       fault_q, fault_d;
    logic [31:0]                instr_count_q, instr_count_d;

    logic [ADDRESS_WIDTH:0]     pc_plus4_ext;
    logic [ADDRESS_WIDTH-1:0]   pc_plus4;
    logic                       target_bad;
    logic                       seq_overflow;
    logic                       d_flush;
    logic                       d_stall;

    assign pc_plus4_ext = {1'b0, pc_q} + (ADDRESS_WIDTH+1)'(4);
    assign pc_plus4     = pc_plus4_ext[ADDRESS_WIDTH-1:0];
    assign seq_overflow = pc_plus4_ext > ROM_HI_EXT;
    assign target_bad   = (PCTargetE[1:0] != 2'b00)
                       || ({1'b0, PCTargetE} < ROM_LO_EXT)
                       || ({1'b0, PCTargetE} > ROM_HI_EXT);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fault_d       = fault_q;
        instr_count_d = instr_count_q;
        d_flush       = 1'b1;
        d_stall       = StallD;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                pc_d    = RESET_VECTOR;
            end
            ST_RUN: begin
                d_flush = FlushD;
                if (PCSrcE) begin
                    if (target_bad) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        d_flush = 1'b1;
                    end else begin
                        pc_d = PCTargetE;
                    end
                end else if (!StallF) begin
                    // The last ROM word still goes to decode; only the step past it faults.
                    if (seq_overflow) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
        endcase
        if (!d_flush && !d_stall) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fault_q       <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fault_q       <= fault_d;
            instr_count_q <= instr_count_d;
        end
    end

    if_id_reg #(
        .ADDRESS_WIDTH     (ADDRESS_WIDTH),
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .stall      (d_stall),
        .flush      (d_flush),
        .pc_f       (pc_q),
        .pc_plus4_f (pc_plus4),
        .instr_f    (RD),
        .pc_d       (PCD),
        .pc_plus4_d (PCPlus4D),
        .instr_d    (InstrD),
        .valid_d    (ValidD)
    );

    assign A          = pc_q;
    assign FetchFault = fault_q;
    assign InstrCount = instr_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table for the boot/stall/redirect/fault corners,
// then randomized traffic against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV      = 32'hBFC00000;
    localparam longint      ROM_LO  = 64'h00000000BFC00000;
    localparam longint      ROM_HI  = 64'h00000000BFC00FFC;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] A, RD, PCD, PCPlus4D, InstrD, InstrCount;
    logic        ValidD, FetchFault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h01234567;
    endfunction

    assign RD = mem_word(A);

    pc_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .A          (A),
        .RD         (RD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .InstrD     (InstrD),
        .ValidD     (ValidD),
        .FetchFault (FetchFault),
        .InstrCount (InstrCount)
    );

    // Behavioural model: plain integer view of PC, decode slot and counters.
    logic [31:0] m_pc, m_pcd, m_pc4, m_ins, m_cnt;
    bit          m_vld, m_boot, m_fault;

    function automatic void m_bubble();
        m_vld = 0; m_pcd = 0; m_pc4 = 0; m_ins = NOP;
    endfunction

    function automatic void model_step(input bit r, sf, sd, fl, src, input logic [31:0] tgt);
        logic [31:0] new_pc;
        bit          kill, go_fault;
        if (r) begin
            m_boot = 1; m_fault = 0; m_pc = RV; m_cnt = 0; m_bubble();
            return;
        end
        if (m_boot) begin
            m_boot = 0; m_bubble();
            return;
        end
        if (m_fault) begin
            m_bubble();
            return;
        end
        new_pc = m_pc; go_fault = 0; kill = fl;
        if (src) begin
            if ((tgt % 4) != 0 || longint'(tgt) < ROM_LO || longint'(tgt) > ROM_HI) begin
                go_fault = 1; kill = 1;
            end else begin
                new_pc = tgt;
            end
        end else if (!sf) begin
            if (longint'(m_pc) + 4 > ROM_HI) go_fault = 1;
            else new_pc = m_pc + 4;
        end
        if (kill) m_bubble();
        else if (!sd) begin
            m_vld = 1; m_pcd = m_pc; m_pc4 = m_pc + 4; m_ins = mem_word(m_pc);
            m_cnt = m_cnt + 1;
        end
        m_pc = new_pc; m_fault = go_fault;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, settle away from the edge.
    task automatic step(input bit r, sf, sd, fl, src, input logic [31:0] tgt);
        rst = r; StallF = sf; StallD = sd; FlushD = fl; PCSrcE = src; PCTargetE = tgt;
        @(posedge clk);
        model_step(r, sf, sd, fl, src, tgt);
        #1;
    endtask

    typedef struct {
        bit          r, sf, sd, fl, src;
        logic [31:0] tgt;
        logic [31:0] a;
        bit          vd;
        logic [31:0] pcd;
        bit          f;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input bit r, sf, sd, fl, src, input logic [31:0] tgt,
                               input logic [31:0] a, input bit vd, input logic [31:0] pcd,
                               input bit f, input logic [31:0] cnt);
        vec_t x;
        x.r = r; x.sf = sf; x.sd = sd; x.fl = fl; x.src = src; x.tgt = tgt;
        x.a = a; x.vd = vd; x.pcd = pcd; x.f = f; x.cnt = cnt;
        return x;
    endfunction

    function automatic void push_boot();
        vecs.push_back(v(1,0,0,0,0,0,            RV,           0, 0,  0, 0));
        vecs.push_back(v(0,0,0,0,0,0,            RV,           0, 0,  0, 0));
        vecs.push_back(v(0,0,0,0,0,0,            32'hBFC00004, 1, RV, 0, 1));
    endfunction

    initial begin
        logic [31:0] tgt;
        bit r, sf, sd, fl, src;

        // reset, boot, first fetch, double stall, redirect with flush, misaligned target
        push_boot();
        vecs.push_back(v(0,0,0,0,0,0,            32'hBFC00008, 1, 32'hBFC00004, 0, 2));
        vecs.push_back(v(0,1,1,0,0,0,            32'hBFC00008, 1, 32'hBFC00004, 0, 2));
        vecs.push_back(v(0,1,1,0,0,0,            32'hBFC00008, 1, 32'hBFC00004, 0, 2));
        vecs.push_back(v(0,0,0,1,1,32'hBFC00100, 32'hBFC00100, 0, 0,            0, 2));
        vecs.push_back(v(0,0,0,0,0,0,            32'hBFC00104, 1, 32'hBFC00100, 0, 3));
        vecs.push_back(v(0,0,0,0,1,32'hBFC00102, 32'hBFC00104, 0, 0,            1, 3));
        vecs.push_back(v(0,0,0,0,0,0,            32'hBFC00104, 0, 0,            1, 3));
        vecs.push_back(v(0,0,0,0,1,32'hBFC00200, 32'hBFC00104, 0, 0,            1, 3));
        // recovery from fault, StallF alone, reset during StallF
        push_boot();
        vecs.push_back(v(0,1,0,0,0,0,            32'hBFC00004, 1, 32'hBFC00004, 0, 2));
        vecs.push_back(v(1,1,0,0,0,0,            RV,           0, 0,            0, 0));
        vecs.push_back(v(0,0,0,0,0,0,            RV,           0, 0,            0, 0));
        vecs.push_back(v(0,0,0,0,0,0,            32'hBFC00004, 1, RV,           0, 1));
        // last ROM word reaches decode, then fault without issuing BFC01000
        vecs.push_back(v(0,0,0,1,1,32'hBFC00FFC, 32'hBFC00FFC, 0, 0,            0, 1));
        vecs.push_back(v(0,0,0,0,0,0,            32'hBFC00FFC, 1, 32'hBFC00FFC, 1, 2));
        vecs.push_back(v(0,0,0,0,0,0,            32'hBFC00FFC, 0, 0,            1, 2));
        // targets just past either end of the ROM
        push_boot();
        vecs.push_back(v(0,0,0,0,1,32'hBFC01000, 32'hBFC00004, 0, 0,            1, 1));
        push_boot();
        vecs.push_back(v(0,0,0,0,1,32'hBFBFFFFC, 32'hBFC00004, 0, 0,            1, 1));
        // redirect while StallD holds decode, then overflow straight from the target
        push_boot();
        vecs.push_back(v(0,0,1,0,1,32'hBFC00FFC, 32'hBFC00FFC, 1, RV,           0, 1));
        vecs.push_back(v(0,0,0,0,0,0,            32'hBFC00FFC, 1, 32'hBFC00FFC, 1, 2));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].src, vecs[i].tgt);
            chk($sformatf("vec%0d_A", i),          A,          vecs[i].a);
            chk($sformatf("vec%0d_ValidD", i),     ValidD,     vecs[i].vd);
            chk($sformatf("vec%0d_PCD", i),        PCD,        vecs[i].pcd);
            chk($sformatf("vec%0d_PCPlus4D", i),   PCPlus4D,   vecs[i].vd ? vecs[i].pcd + 32'd4 : 32'd0);
            chk($sformatf("vec%0d_InstrD", i),     InstrD,     vecs[i].vd ? mem_word(vecs[i].pcd) : NOP);
            chk($sformatf("vec%0d_FetchFault", i), FetchFault, vecs[i].f);
            chk($sformatf("vec%0d_InstrCount", i), InstrCount, vecs[i].cnt);
        end

        step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 39) == 0);
            sf  = ($urandom_range(0, 3) == 0);
            sd  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            src = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0:       tgt = (RV + ($urandom_range(0, 1023) << 2)) | $urandom_range(1, 3);
                1:       tgt = $urandom;
                2, 3:    tgt = 32'hBFC00FF0 + ($urandom_range(0, 3) << 2);
                4:       tgt = ($urandom_range(0, 1) == 0) ? 32'hBFC01000 : 32'hBFBFFFFC;
                default: tgt = RV + ($urandom_range(0, 1023) << 2);
            endcase
            step(r, sf, sd, fl, src, tgt);
            chk("rnd_A",          A,          m_pc);
            chk("rnd_ValidD",     ValidD,     m_vld);
            chk("rnd_PCD",        PCD,        m_pcd);
            chk("rnd_PCPlus4D",   PCPlus4D,   m_pc4);
            chk("rnd_InstrD",     InstrD,     m_ins);
            chk("rnd_FetchFault", FetchFault, m_fault);
            chk("rnd_InstrCount", InstrCount, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning the PC and instruction-memory address width.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32, meaning the instruction word width.
REQ-003 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the first fetch address and the ROM base.
REQ-004 SHALL have parameter ROM_LAST, default 32'hBFC00FFF, meaning the last valid ROM byte address.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port StallF, input, 1 bit: hold PCF.
REQ-008 SHALL have port StallD, input, 1 bit: hold the IF/ID register.
REQ-009 SHALL have port FlushD, input, 1 bit: load a bubble into the IF/ID register.
REQ-010 SHALL have port PCSrcE, input, 1 bit: redirect request.
REQ-011 SHALL have port PCTargetE, input, ADDRESS_WIDTH bits: redirect target.
REQ-012 SHALL have port A, output, ADDRESS_WIDTH bits: instruction-memory address, equal to PCF.
REQ-013 SHALL have port RD, input, INSTRUCTION_WIDTH bits: asynchronous instruction-memory read data for A.
REQ-014 SHALL have ports PCD and PCPlus4D, outputs, ADDRESS_WIDTH bits each: the PC of the decode-stage instruction and that PC+4.
REQ-015 SHALL have port InstrD, output, INSTRUCTION_WIDTH bits: the decode-stage instruction.
REQ-016 SHALL have port ValidD, output, 1 bit: InstrD is a real fetched instruction.
REQ-017 SHALL have port FetchFault, output, 1 bit: sticky fault flag.
REQ-018 SHALL have port InstrCount, output, 32 bits: count of valid instructions delivered to D.

Function
REQ-019 SHALL implement a three-state FSM BOOT, RUN, FAULT; BOOT SHALL always go to RUN after one cycle; FAULT SHALL be left only by rst.
REQ-020 SHALL, in BOOT, hold PCF at RESET_VECTOR and load a bubble into the IF/ID register.
REQ-021 SHALL, in RUN, use next-PC priority: PCSrcE (target), then StallF (hold), then PCF+4.
REQ-022 SHALL enter FAULT, hold PCF, and load a bubble into D when an accepted PCTargetE has [1:0]!=0 or lies outside RESET_VECTOR..ROM_LAST-3.
REQ-023 SHALL likewise enter FAULT when an advancing PCF+4 exceeds ROM_LAST-3 (PCF=BFC00FFC wraps to fault, never to BFC01000).
REQ-024 SHALL, in FAULT, assert FetchFault, freeze PCF, and hold the D stage as a bubble.
REQ-025 SHALL use IF/ID update priority: FlushD (bubble), then StallD (hold), then load {PCF, PCF+4, RD, ValidD=1}.
REQ-026 SHALL, when simultaneous, apply PCSrcE to PCF while FlushD bubbles D in the same cycle.
REQ-027 SHALL define a bubble as InstrD=32'h00000013 (NOP), PCD=0, PCPlus4D=0, ValidD=0.
REQ-028 SHALL have a fetch latency of one cycle: RD sampled at edge N appears on InstrD after edge N.
REQ-029 SHALL compute all address arithmetic modulo 2^ADDRESS_WIDTH, with bounds checks on the unwrapped result.
REQ-030 SHALL increment InstrCount only on edges loading ValidD=1, wrapping 0xFFFFFFFF to 0.

Reset
REQ-031 SHALL, on rst high at a clock edge: set state to BOOT, PCF to RESET_VECTOR, D to a bubble, FetchFault to 0, InstrCount to 0.
REQ-032 SHALL give rst priority over all other inputs, including in FAULT and in mid-stall.
REQ-033 SHALL drive A combinationally from PCF; A SHALL be valid in the cycle after reset.

Structure
REQ-034 SHALL take RESET_VECTOR, ROM_LAST, the NOP encoding and the FSM state enum from shared package fetch_pkg.
REQ-035 SHALL instantiate the IF/ID register as sub-module if_id_reg (stall, flush, bubble load); the PC, FSM and counter stay in pc_fetch_unit.

Verification
REQ-036 SHALL cover reset then 3 free cycles -> A = BFC00000, BFC00000, BFC00004; ValidD=0, then 1 with PCD=BFC00000; InstrCount=1.
REQ-037 SHALL cover StallF=StallD=1 for 2 cycles at PCF=BFC00008 -> PCF and D unchanged; InstrCount frozen.
REQ-038 SHALL cover PCSrcE=1, PCTargetE=BFC00100, FlushD=1 -> next PCF=BFC00100 with D bubble, and the following D has PCD=BFC00100.
REQ-039 SHALL cover PCTargetE=BFC00102 -> FetchFault=1, PCF holds, ValidD=0 until rst; rst -> PCF=BFC00000, FetchFault=0.
REQ-040 SHALL cover sequential fetch reaching PCF=BFC00FFC -> that instruction reaches D, then FetchFault=1 with no address BFC01000 issued.
REQ-041 SHALL cover rst asserted during StallF -> BOOT restart at BFC00000, InstrCount=0.
